// File: rtl/tuple_sum_pkg.sv
// Shared types and helpers for the pair-sum search over the tuple_sum ROM.
package tuple_sum_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    // Search controller states; also exported on the bus for observation.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_I = 3'd1,
        SCAN_J = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Sign-extend both two's-complement words by one bit before adding, so
    // the sum can never wrap (127 + 127 stays +254, not -2).
    function automatic logic [DEF_DATA_W:0] sext_add(
        input logic [DEF_DATA_W-1:0] a,
        input logic [DEF_DATA_W-1:0] b
    );
        return {a[DEF_DATA_W-1], a} + {b[DEF_DATA_W-1], b};
    endfunction

endpackage

// File: rtl/pair_sum_finder_if.sv
// Bus bundle between the pair-sum search engine (master) and its
// environment: control, ROM port, result port and status.
//
// Result handshake: res_valid/res_ready are strict valid/ready. A pair
// transfers on every rising edge where both are high. Once res_valid is
// raised, res_valid, res_i and res_j hold stable until that transfer;
// res_ready may toggle freely and is ignored while res_valid is low.
interface pair_sum_finder_if
    import tuple_sum_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
);

    logic              start;
    logic [DATA_W-1:0] target;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_cs;
    logic [DATA_W-1:0] rom_dout;
    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] res_i;
    logic [ADDR_W-1:0] res_j;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pair_count;
    state_t            fsm_state;

    modport master (
        input  start, target, rom_dout, res_ready,
        output rom_addr, rom_cs, res_valid, res_i, res_j,
               busy, done, pair_count, fsm_state
    );

    modport slave (
        output start, target, rom_dout, res_ready,
        input  rom_addr, rom_cs, res_valid, res_i, res_j,
               busy, done, pair_count, fsm_state
    );

endinterface

// File: rtl/pair_sum_finder_index_gen.sv
// Nested i/j counter that walks every index pair i<j over N_ENTRIES words.
// Counters are one bit wider than the address so N_ENTRIES=256 terminal
// counts compare cleanly without wrapping.
module pair_index_gen #(
    parameter int N_ENTRIES = 8,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load_j,
    input  logic              step,
    output logic [ADDR_W-1:0] i,
    output logic [ADDR_W-1:0] j,
    output logic              last_j,
    output logic              last_pair
);

    localparam int LAST_J_INT = (N_ENTRIES >= 1) ? N_ENTRIES - 1 : 0;
    localparam int LAST_I_INT = (N_ENTRIES >= 2) ? N_ENTRIES - 2 : 0;
    localparam logic [ADDR_W:0] LAST_J = LAST_J_INT[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST_I = LAST_I_INT[ADDR_W:0];

    logic [ADDR_W:0] i_cnt;
    logic [ADDR_W:0] j_cnt;
    logic            last_i;

    assign last_j    = (j_cnt == LAST_J);
    assign last_i    = (i_cnt == LAST_I);
    assign last_pair = last_j && last_i;
    assign i         = i_cnt[ADDR_W-1:0];
    assign j         = j_cnt[ADDR_W-1:0];

    // clear restarts the walk, load_j begins a row at i+1, step advances
    // j within the row or moves i to the next row at the row end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt <= '0;
            j_cnt <= '0;
        end else if (clear) begin
            i_cnt <= '0;
            j_cnt <= '0;
        end else if (load_j) begin
            j_cnt <= i_cnt + (ADDR_W+1)'(1);
        end else if (step) begin
            if (!last_j) begin
                j_cnt <= j_cnt + (ADDR_W+1)'(1);
            end else if (!last_i) begin
                i_cnt <= i_cnt + (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pair_sum_finder.sv
// Pair-sum search engine: reads the first N_ENTRIES ROM words, finds every
// pair (i<j) whose signed sum equals the latched target, reports each pair
// over the result handshake and ends with a one-cycle done pulse.
module pair_sum_finder
    import tuple_sum_pkg::*;
#(
    parameter int N_ENTRIES = 8,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = 16
) (
    input logic               clk,
    input logic               rst_n,
    pair_sum_finder_if.master bus
);

    localparam bit SHORT_RUN = (N_ENTRIES < 2);

    state_t            state;
    state_t            state_nxt;
    state_t            adv_state;

    logic [DATA_W-1:0] tgt_reg;
    logic [DATA_W-1:0] a_reg;
    logic              res_valid;
    logic [ADDR_W-1:0] res_i;
    logic [ADDR_W-1:0] res_j;
    logic [CNT_W-1:0]  pair_count;

    logic              idx_clear;
    logic              idx_load;
    logic              idx_step;
    logic [ADDR_W-1:0] idx_i;
    logic [ADDR_W-1:0] idx_j;
    logic              last_j;
    logic              last_pair;

    logic [DATA_W:0]   pair_sum;
    logic              match;
    logic              handshake;

    pair_index_gen #(
        .N_ENTRIES (N_ENTRIES),
        .ADDR_W    (ADDR_W)
    ) u_index_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (idx_clear),
        .load_j    (idx_load),
        .step      (idx_step),
        .i         (idx_i),
        .j         (idx_j),
        .last_j    (last_j),
        .last_pair (last_pair)
    );

    assign pair_sum  = sext_add(a_reg, bus.rom_dout);
    assign match     = (pair_sum == {tgt_reg[DATA_W-1], tgt_reg});
    assign handshake = res_valid && bus.res_ready;

    // Where the walk goes after a pair is finished (no match or emitted).
    always_comb begin
        adv_state = SCAN_J;
        if (last_j) begin
            adv_state = last_pair ? DONE : LOAD_I;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, ROM port and index-counter controls.
    always_comb begin
        state_nxt    = state;
        idx_clear    = 1'b0;
        idx_load     = 1'b0;
        idx_step     = 1'b0;
        bus.rom_cs   = 1'b0;
        bus.rom_addr = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_clear = 1'b1;
                    state_nxt = SHORT_RUN ? DONE : LOAD_I;
                end
            end
            LOAD_I: begin
                bus.rom_cs   = 1'b1;
                bus.rom_addr = idx_i;
                idx_load     = 1'b1;
                state_nxt    = SCAN_J;
            end
            SCAN_J: begin
                bus.rom_cs   = 1'b1;
                bus.rom_addr = idx_j;
                if (match) begin
                    state_nxt = EMIT;
                end else begin
                    idx_step  = 1'b1;
                    state_nxt = adv_state;
                end
            end
            EMIT: begin
                if (handshake) begin
                    idx_step  = 1'b1;
                    state_nxt = adv_state;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: target latch, row word, result registers and match count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_reg    <= '0;
            a_reg      <= '0;
            res_valid  <= 1'b0;
            res_i      <= '0;
            res_j      <= '0;
            pair_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tgt_reg    <= bus.target;
                        pair_count <= '0;
                    end
                end
                LOAD_I: begin
                    a_reg <= bus.rom_dout;
                end
                SCAN_J: begin
                    if (match) begin
                        res_i     <= idx_i;
                        res_j     <= idx_j;
                        res_valid <= 1'b1;
                        if (pair_count != {CNT_W{1'b1}}) begin
                            pair_count <= pair_count + CNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.res_valid  = res_valid;
    assign bus.res_i      = res_i;
    assign bus.res_j      = res_j;
    assign bus.pair_count = pair_count;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.fsm_state  = state;

endmodule

// File: tb/tb_pair_sum_finder.sv
// Bench for pair_sum_finder: an 8-word instance over the tuple_sum ROM and a
// 2-word instance over a stub ROM, checked by queue-based scoreboards.
module tb_pair_sum_finder;
    import tuple_sum_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pair_sum_finder_if bus_a ();
    pair_sum_finder_if bus_b ();

    logic [7:0] rom_a [256];
    logic [7:0] rom_b [256];

    assign bus_a.rom_dout  = rom_a[bus_a.rom_addr];
    assign bus_b.rom_dout  = rom_b[bus_b.rom_addr];
    assign bus_b.res_ready = 1'b1;

    pair_sum_finder #(.N_ENTRIES(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.master));
    pair_sum_finder #(.N_ENTRIES(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.master));

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_a_q [$];
    logic [15:0] cnt_a_q [$];
    logic [15:0] exp_b_q [$];
    logic [15:0] cnt_b_q [$];

    bit rdy_rand = 1'b0;
    bit rdy_a    = 1'b1;

    // Consumer ready for instance A: forced level or random.
    always @(posedge clk) begin
        #1;
        bus_a.res_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_a;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // ---------------- reference model ----------------
    // Every pair i<j over the first n words whose true signed sum is t.
    task automatic push_model(input bit to_b, input int n, input logic [7:0] t);
        int found = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = i + 1; j < n; j++) begin
                int s;
                s = to_b ? int'($signed(rom_b[i])) + int'($signed(rom_b[j]))
                         : int'($signed(rom_a[i])) + int'($signed(rom_a[j]));
                if (s == int'($signed(t))) begin
                    if (to_b) exp_b_q.push_back({8'(i), 8'(j)});
                    else      exp_a_q.push_back({8'(i), 8'(j)});
                    found++;
                end
            end
        end
        if (to_b) cnt_b_q.push_back(16'(found));
        else      cnt_a_q.push_back(16'(found));
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_a.res_valid && bus_a.res_ready) begin
                if (exp_a_q.size() == 0) fail_now("a_extra_pair");
                else check("a_pair", {bus_a.res_i, bus_a.res_j}, exp_a_q.pop_front());
            end
            if (bus_a.done) begin
                if (cnt_a_q.size() == 0) fail_now("a_extra_done");
                else check("a_pair_count", bus_a.pair_count, cnt_a_q.pop_front());
                check("a_missing_pairs", exp_a_q.size(), 0);
                exp_a_q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_b.res_valid && bus_b.res_ready) begin
                if (exp_b_q.size() == 0) fail_now("b_extra_pair");
                else check("b_pair", {bus_b.res_i, bus_b.res_j}, exp_b_q.pop_front());
            end
            if (bus_b.done) begin
                if (cnt_b_q.size() == 0) fail_now("b_extra_done");
                else check("b_pair_count", bus_b.pair_count, cnt_b_q.pop_front());
                check("b_missing_pairs", exp_b_q.size(), 0);
                exp_b_q.delete();
            end
        end
    end

    // ---------------- drivers ----------------
    // One search on instance A; cyc counts rising edges from the edge that
    // samples start up to the edge that enters DONE.
    task automatic run_a(input logic [7:0] t, input bit mid_start, output int cyc);
        push_model(1'b0, 8, t);
        @(posedge clk); #1;
        bus_a.start  = 1'b1;
        bus_a.target = t;
        @(posedge clk); #1;
        bus_a.start  = 1'b0;
        bus_a.target = 8'($urandom);
        cyc = 1;
        while (!bus_a.done && cyc < 2000) begin
            bus_a.start = (mid_start && cyc == 10);
            @(posedge clk); #1;
            cyc++;
            bus_a.target = 8'($urandom);
        end
        bus_a.start = 1'b0;
        if (!bus_a.done) fail_now("a_done_timeout");
        @(posedge clk); #1;
    endtask

    task automatic run_b(input logic [7:0] t);
        int cyc = 0;
        push_model(1'b1, 2, t);
        @(posedge clk); #1;
        bus_b.start  = 1'b1;
        bus_b.target = t;
        @(posedge clk); #1;
        bus_b.start  = 1'b0;
        while (!bus_b.done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus_b.done) fail_now("b_done_timeout");
        @(posedge clk); #1;
    endtask

    // Hold ready low for five cycles of res_valid and require a stable pair.
    task automatic hold_check();
        int n = 0;
        logic [15:0] e;
        while (!bus_a.res_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_a.res_valid) begin
            fail_now("hold_valid_timeout");
        end else begin
            e = exp_a_q[0];
            for (int k = 0; k < 5; k++) begin
                check("hold_valid", bus_a.res_valid, 1);
                check("hold_pair", {bus_a.res_i, bus_a.res_j}, e);
                @(posedge clk); #1;
            end
        end
        rdy_a = 1'b1;
    endtask

    function automatic logic [63:0] outs_a();
        return {bus_a.rom_addr, bus_a.rom_cs, bus_a.res_valid, bus_a.res_i, bus_a.res_j,
                bus_a.busy, bus_a.done, bus_a.pair_count};
    endfunction

    function automatic logic [63:0] outs_b();
        return {bus_b.rom_addr, bus_b.rom_cs, bus_b.res_valid, bus_b.res_i, bus_b.res_j,
                bus_b.busy, bus_b.done, bus_b.pair_count};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int exp_lat;
        int n;

        for (int k = 0; k < 256; k++) begin
            rom_a[k] = 8'h00;
            rom_b[k] = 8'h00;
        end
        rom_a[0] = -8'sd5; rom_a[1] = -8'sd2; rom_a[2] = -8'sd3; rom_a[3] = 8'sd5;
        rom_a[4] = 8'sd3;  rom_a[5] = 8'sd0;  rom_a[6] = 8'sd2;  rom_a[7] = 8'sd1;
        bus_a.start = 1'b0; bus_a.target = 8'h00;
        bus_b.start = 1'b0; bus_b.target = 8'h00;

        #23;
        check("reset_outs_a", outs_a(), 0);
        check("reset_state_a", bus_a.fsm_state, IDLE);
        check("reset_outs_b", outs_b(), 0);
        check("reset_state_b", bus_b.fsm_state, IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_a(8'sd0, 1'b0, cyc);
        run_a(8'sd3, 1'b0, cyc);

        rdy_a = 1'b0;
        fork
            run_a(-8'sd8, 1'b0, cyc);
            hold_check();
        join

        // No matches: latency is one start cycle plus one load and N-1-i scans per row.
        exp_lat = 1;
        for (int i = 0; i <= 6; i++) exp_lat += 1 + (8 - 1 - i);
        run_a(8'sd127, 1'b0, cyc);
        check("latency_no_match", cyc, exp_lat);

        // Stub ROM: no 8-bit wrap, then a genuine -2 match.
        rom_b[0] = 8'sd127; rom_b[1] = 8'sd127;
        run_b(-8'sd2);
        rom_b[0] = -8'sd1;  rom_b[1] = -8'sd1;
        run_b(-8'sd2);

        // Reset during EMIT of a target=0 run.
        rdy_a = 1'b0;
        push_model(1'b0, 8, 8'sd0);
        @(posedge clk); #1;
        bus_a.start = 1'b1; bus_a.target = 8'sd0;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        n = 0;
        while (!bus_a.res_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("emit_before_reset", bus_a.fsm_state, EMIT);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outs_a", outs_a(), 0);
        check("abort_state_a", bus_a.fsm_state, IDLE);
        exp_a_q.delete();
        cnt_a_q.delete();
        @(posedge clk); #1;
        check("abort_hold_outs_a", outs_a(), 0);
        rst_n = 1'b1;
        rdy_a = 1'b1;
        run_a(8'sd0, 1'b0, cyc);

        // Start re-asserted mid-search must not disturb the run.
        run_a(8'sd3, 1'b1, cyc);

        // Random ROM contents, targets and ready back-pressure.
        rdy_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
                rom_a[k] = (r == 7) ? 8'($urandom) : 8'($urandom_range(0, 14) - 7);
            end
            run_a((r == 7) ? 8'($urandom) : 8'($urandom_range(0, 14) - 7), r[0], cyc);
        end
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);
        check("final_queue_a", exp_a_q.size() + cnt_a_q.size(), 0);
        check("final_queue_b", exp_b_q.size() + cnt_b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
